// File: rtl/bidir_fifo_port.sv
// bidir_fifo_port: two independent FIFOs (A->B, B->A) between tri-state buses a and b.
// Ports: clk/rst (sync, active-high); a, b inout buses; ld_a/rd_b/oe_b_ control the
// A->B FIFO; ld_b/rd_a/oe_a_ control the B->A FIFO; empty_*/full_*/count_* status;
// err sticky overflow/underflow, cleared by clr_err.
// Optional macro BIDIR_FIFO_PORT_IRQ_EN adds ie_ab, ie_ba inputs and active-low irq_.
module bidir_fifo_port #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int INVERT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire  [WIDTH-1:0]           a,
  inout  wire  [WIDTH-1:0]           b,
  input  logic                       ld_a,
  input  logic                       rd_b,
  input  logic                       oe_b_,
  input  logic                       ld_b,
  input  logic                       rd_a,
  input  logic                       oe_a_,
  output logic                       empty_ab,
  output logic                       full_ab,
  output logic                       empty_ba,
  output logic                       full_ba,
  output logic [$clog2(DEPTH+1)-1:0] count_ab,
  output logic [$clog2(DEPTH+1)-1:0] count_ba,
  output logic                       err,
  input  logic                       clr_err
`ifdef BIDIR_FIFO_PORT_IRQ_EN
  ,
  input  logic                       ie_ab,
  input  logic                       ie_ba,
  output logic                       irq_
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // index 0 = A->B direction, index 1 = B->A direction
  logic [WIDTH-1:0]         mem [2][DEPTH];
  logic [1:0][PW-1:0]       wp, rp;
  logic [1:0][CW-1:0]       cnt, cnt_nxt;
  logic [1:0][WIDTH-1:0]    din;
  logic [1:0]               push, pop, full, empty, do_push, do_pop, bad;
  assign push = {ld_b, ld_a};
  assign pop  = {rd_a, rd_b};
  assign din  = {b, a};
  always_comb begin
    full    = '0;
    empty   = '0;
    do_push = '0;
    do_pop  = '0;
    bad     = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < 2; i++) begin
      full[i]    = cnt[i] == CW'(DEPTH);
      empty[i]   = cnt[i] == '0;
      // a pop frees the slot in the same edge, so push-while-full succeeds only alongside a pop
      do_push[i] = push[i] && (!full[i] || pop[i]);
      // no read-through: an empty FIFO never pops, even with a simultaneous push
      do_pop[i]  = pop[i] && !empty[i];
      bad[i]     = (push[i] && full[i] && !pop[i]) || (pop[i] && empty[i] && !push[i]);
      cnt_nxt[i] = cnt[i] + CW'(do_push[i]) - CW'(do_pop[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      err <= 1'b0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (do_push[i]) mem[i][wp[i]] <= INVERT != 0 ? ~din[i] : din[i];
        wp[i] <= wp[i] + PW'(do_push[i]);
        rp[i] <= rp[i] + PW'(do_pop[i]);
      end
      cnt <= cnt_nxt;
      // a new error event wins over a same-cycle clear
      err <= (|bad) || (err && !clr_err);
    end
  end
  assign empty_ab = empty[0];
  assign full_ab  = full[0];
  assign empty_ba = empty[1];
  assign full_ba  = full[1];
  assign count_ab = cnt[0];
  assign count_ba = cnt[1];
  assign b = (!oe_b_ && !empty[0]) ? mem[0][rp[0]] : 'z;
  assign a = (!oe_a_ && !empty[1]) ? mem[1][rp[1]] : 'z;
`ifdef BIDIR_FIFO_PORT_IRQ_EN
  // evaluated from next-state counts so irq_ falls together with empty_* after the edge
  always_ff @(posedge clk) begin
    if (rst) irq_ <= 1'b1;
    else irq_ <= !((ie_ab && cnt_nxt[0] != '0) || (ie_ba && cnt_nxt[1] != '0));
  end
`endif
endmodule

// File: tb/tb_bidir_fifo_port.sv
// tb_bidir_fifo_port: directed self-checking bench for bidir_fifo_port.
// Bus nets are pulled up, so a released (Z) bus reads 8'hFF.
module tb_bidir_fifo_port;
  logic clk = 0;
  logic rst = 0, ld_a = 0, rd_b = 0, oe_b_ = 1, ld_b = 0, rd_a = 0, oe_a_ = 1, clr_err = 0;
  logic a_en = 0, b_en = 0;
  logic [7:0] a_drv = 0, b_drv = 0;
  logic empty_ab, full_ab, empty_ba, full_ba, err;
  logic [2:0] count_ab, count_ba;
  tri1 [7:0] a, b;
  logic ld_b1 = 0, rd_a1 = 0, oe_a1_ = 1, oe_b1_ = 1, b1_en = 0;
  logic [7:0] b1_drv = 0;
  logic empty_ab1, full_ab1, empty_ba1, full_ba1, err1;
  logic [2:0] count_ab1, count_ba1;
  tri1 [7:0] a1, b1;
  int checks = 0, failures = 0;
`ifdef BIDIR_FIFO_PORT_IRQ_EN
  logic ie_ab = 0, ie_ba = 0, irq_;
`endif
  assign a  = a_en  ? a_drv  : 'z;
  assign b  = b_en  ? b_drv  : 'z;
  assign b1 = b1_en ? b1_drv : 'z;
  always #5 clk = ~clk;

  bidir_fifo_port #(.WIDTH(8), .DEPTH(4), .INVERT(1)) u0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .ld_a(ld_a), .rd_b(rd_b), .oe_b_(oe_b_),
    .ld_b(ld_b), .rd_a(rd_a), .oe_a_(oe_a_), .empty_ab(empty_ab), .full_ab(full_ab),
    .empty_ba(empty_ba), .full_ba(full_ba), .count_ab(count_ab), .count_ba(count_ba),
    .err(err), .clr_err(clr_err)
`ifdef BIDIR_FIFO_PORT_IRQ_EN
    , .ie_ab(ie_ab), .ie_ba(ie_ba), .irq_(irq_)
`endif
  );

  bidir_fifo_port #(.WIDTH(8), .DEPTH(4), .INVERT(0)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .ld_a(1'b0), .rd_b(1'b0), .oe_b_(oe_b1_),
    .ld_b(ld_b1), .rd_a(rd_a1), .oe_a_(oe_a1_), .empty_ab(empty_ab1), .full_ab(full_ab1),
    .empty_ba(empty_ba1), .full_ba(full_ba1), .count_ab(count_ab1), .count_ba(count_ba1),
    .err(err1), .clr_err(1'b0)
`ifdef BIDIR_FIFO_PORT_IRQ_EN
    , .ie_ab(1'b0), .ie_ba(1'b0), .irq_()
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
  endtask

  task automatic fill;
    for (int i = 1; i <= 4; i++) begin
      a_en = 1; a_drv = 8'(i); ld_a = 1;
      tick;
    end
    ld_a = 0; a_en = 0;
  endtask

  task automatic pop_b;
    rd_b = 1;
    tick;
    rd_b = 0;
  endtask

  task automatic test_reset;
    oe_a_ = 0; oe_b_ = 0;
    do_reset;
    checks++; if (empty_ab !== 1'b1) begin failures++; $display("FAIL reset_empty_ab got=%b exp=1", empty_ab); end
    checks++; if (empty_ba !== 1'b1) begin failures++; $display("FAIL reset_empty_ba got=%b exp=1", empty_ba); end
    checks++; if (count_ab !== 3'd0) begin failures++; $display("FAIL reset_count_ab got=%0d exp=0", count_ab); end
    checks++; if (count_ba !== 3'd0) begin failures++; $display("FAIL reset_count_ba got=%0d exp=0", count_ba); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (a !== 8'hFF) begin failures++; $display("FAIL reset_a_released got=%h exp=ff", a); end
    checks++; if (b !== 8'hFF) begin failures++; $display("FAIL reset_b_released got=%h exp=ff", b); end
    oe_a_ = 1;
  endtask

  task automatic test_fill;
    do_reset;
    oe_b_ = 0;
    fill;
    checks++; if (full_ab !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full_ab); end
    checks++; if (count_ab !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_ab); end
    checks++; if (b !== 8'hFE) begin failures++; $display("FAIL fill_head got=%h exp=fe", b); end
    pop_b;
    checks++; if (b !== 8'hFD) begin failures++; $display("FAIL pop_head got=%h exp=fd", b); end
    checks++; if (count_ab !== 3'd3) begin failures++; $display("FAIL pop_count got=%0d exp=3", count_ab); end
  endtask

  task automatic test_overflow;
    logic [7:0] heads [4];
    heads = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
    do_reset;
    oe_b_ = 0;
    fill;
    a_en = 1; a_drv = 8'h05; ld_a = 1;
    tick;
    ld_a = 0; a_en = 0;
    checks++; if (count_ab !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count_ab); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (b !== heads[k]) begin failures++; $display("FAIL ovf_head%0d got=%h exp=%h", k, b, heads[k]); end
      pop_b;
    end
    checks++; if (empty_ab !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty_ab); end
    checks++; if (b !== 8'hFF) begin failures++; $display("FAIL drain_b_released got=%h exp=ff", b); end
    rd_b = 1; clr_err = 1;
    tick;
    rd_b = 0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_priority got=%b exp=1", err); end
    checks++; if (count_ab !== 3'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", count_ab); end
    tick;
    clr_err = 0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", err); end
  endtask

  task automatic test_full_push_pop;
    do_reset;
    oe_b_ = 0;
    fill;
    a_en = 1; a_drv = 8'h10; ld_a = 1; rd_b = 1;
    tick;
    ld_a = 0; a_en = 0; rd_b = 0;
    checks++; if (count_ab !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", count_ab); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fpp_err got=%b exp=0", err); end
    checks++; if (b !== 8'hFD) begin failures++; $display("FAIL fpp_head got=%h exp=fd", b); end
    for (int k = 0; k < 3; k++) pop_b;
    checks++; if (b !== 8'hEF) begin failures++; $display("FAIL fpp_wrap_head got=%h exp=ef", b); end
  endtask

  task automatic test_empty_push_pop;
    do_reset;
    oe_b_ = 1; oe_a_ = 0;
    b_en = 1; b_drv = 8'h0F; ld_b = 1;
    tick;
    ld_b = 0; b_en = 0;
    checks++; if (a !== 8'hF0) begin failures++; $display("FAIL ba_head got=%h exp=f0", a); end
    checks++; if (count_ba !== 3'd1) begin failures++; $display("FAIL ba_count got=%0d exp=1", count_ba); end
    checks++; if (count_ab !== 3'd0) begin failures++; $display("FAIL ba_indep_ab got=%0d exp=0", count_ab); end
    oe_a_ = 1; oe_b_ = 0;
    a_en = 1; a_drv = 8'h33; ld_a = 1; rd_b = 1;
    tick;
    ld_a = 0; a_en = 0; rd_b = 0;
    checks++; if (count_ab !== 3'd1) begin failures++; $display("FAIL epp_count got=%0d exp=1", count_ab); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL epp_err got=%b exp=0", err); end
    checks++; if (b !== 8'hCC) begin failures++; $display("FAIL epp_head got=%h exp=cc", b); end
    checks++; if (count_ba !== 3'd1) begin failures++; $display("FAIL epp_indep_ba got=%0d exp=1", count_ba); end
  endtask

  task automatic test_invert0;
    oe_a1_ = 0; oe_b1_ = 1;
    b1_en = 1; b1_drv = 8'hA5; ld_b1 = 1;
    tick;
    ld_b1 = 0; b1_en = 0;
    checks++; if (a1 !== 8'hA5) begin failures++; $display("FAIL inv0_head got=%h exp=a5", a1); end
    checks++; if (count_ba1 !== 3'd1) begin failures++; $display("FAIL inv0_count got=%0d exp=1", count_ba1); end
    rd_a1 = 1;
    tick;
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL inv0_pop_err got=%b exp=0", err1); end
    checks++; if (empty_ba1 !== 1'b1) begin failures++; $display("FAIL inv0_empty got=%b exp=1", empty_ba1); end
    tick;
    rd_a1 = 0;
    checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL inv0_unf_err got=%b exp=1", err1); end
  endtask

`ifdef BIDIR_FIFO_PORT_IRQ_EN
  task automatic test_irq;
    oe_a_ = 1; oe_b_ = 1;
    do_reset;
    checks++; if (irq_ !== 1'b1) begin failures++; $display("FAIL irq_reset got=%b exp=1", irq_); end
    ie_ab = 1;
    a_en = 1; a_drv = 8'h01; ld_a = 1;
    tick;
    ld_a = 0;
    checks++; if (irq_ !== 1'b0) begin failures++; $display("FAIL irq_assert got=%b exp=0", irq_); end
    pop_b;
    checks++; if (irq_ !== 1'b1) begin failures++; $display("FAIL irq_deassert got=%b exp=1", irq_); end
    ie_ab = 0; ld_a = 1;
    tick;
    ld_a = 0; a_en = 0;
    checks++; if (irq_ !== 1'b1) begin failures++; $display("FAIL irq_masked got=%b exp=1", irq_); end
  endtask
`endif

  initial begin
    tick;
    test_reset;
    test_fill;
    test_overflow;
    test_full_push_pop;
    test_empty_push_pop;
    test_invert0;
`ifdef BIDIR_FIFO_PORT_IRQ_EN
    test_irq;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
